// File: rtl/tqvp_vga_copper.sv
// Copper: a 12-entry display list that waits on the beam position and issues
// VGA register writes through a master port that the CPU always outranks.
module tqvp_vga_copper #(
  parameter int LIST_LEN = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [5:0]  address,
  input  logic [31:0] data_in,
  input  logic [1:0]  data_write_n,
  input  logic [1:0]  data_read_n,
  output logic [31:0] data_out,
  output logic        data_ready,
  input  logic [9:0]  vga_y,
  input  logic        vga_new_scanline,
  input  logic        frame_start,
  input  logic        m_busy,
  output logic [5:0]  m_address,
  output logic [31:0] m_data,
  output logic [1:0]  m_write_n
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH     = 3'd1,
    S_WAIT_Y    = 3'd2,
    S_WAIT_LINE = 3'd3,
    S_MOVE      = 3'd4,
    S_HALT      = 3'd5
  } state_t;

  localparam logic [3:0] LAST_PC  = 4'(LIST_LEN - 1);
  localparam logic [3:0] CTRL_IDX = 4'd12;
  localparam logic [3:0] STAT_IDX = 4'd13;

  state_t      state;
  logic [3:0]  pc;
  logic        enable;
  logic [9:0]  cmd_y;
  logic [31:0] list [LIST_LEN];
  logic [31:0] fetch_word;
  logic        list_wr;
  logic        ctrl_wr;
  logic        step_done;
  logic        unused_ok;

  assign data_ready = 1'b1;
  assign unused_ok  = &{1'b0, data_read_n, address[1:0]};

  assign list_wr    = (data_write_n == 2'b10) && (address[5:2] <= LAST_PC);
  assign ctrl_wr    = (data_write_n != 2'b11) && (address[5:2] == CTRL_IDX);
  assign fetch_word = list[pc];

  // Master handshake: m_write_n==10 is "valid"; !m_busy is "ready". The
  // offer is held with stable address/data until a cycle where both are true.
  always_comb begin
    step_done = 1'b0;
    case (state)
      S_WAIT_Y:    step_done = (vga_y >= cmd_y);
      S_WAIT_LINE: step_done = vga_new_scanline;
      S_MOVE:      step_done = !m_busy;
      default:     step_done = 1'b0;
    endcase
  end

  always_comb begin
    data_out = 32'd0;
    if (address[5:2] <= LAST_PC) data_out = list[address[5:2]];
    else if (address[5:2] == CTRL_IDX) data_out = {31'd0, enable};
    else if (address[5:2] == STAT_IDX) data_out = {25'd0, pc, state};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < LIST_LEN; i++) list[i] <= 32'd0;
    end else if (list_wr) begin
      list[address[5:2]] <= data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      pc        <= 4'd0;
      enable    <= 1'b0;
      cmd_y     <= 10'd0;
      m_write_n <= 2'b11;
      m_address <= 6'd0;
      m_data    <= 32'd0;
    end else begin
      if (ctrl_wr) enable <= data_in[0];

      if (!enable || (ctrl_wr && !data_in[0])) begin
        state     <= S_IDLE;
        pc        <= 4'd0;
        m_write_n <= 2'b11;
      end else if (frame_start) begin
        // A new frame restarts the list and abandons any unaccepted write.
        state     <= S_FETCH;
        pc        <= 4'd0;
        m_write_n <= 2'b11;
      end else begin
        case (state)
          S_FETCH: begin
            case (fetch_word[31:30])
              2'b00: begin
                cmd_y <= fetch_word[9:0];
                state <= S_WAIT_Y;
              end
              2'b01: begin
                m_address <= fetch_word[21:16];
                m_data    <= {16'd0, fetch_word[15:0]};
                m_write_n <= 2'b10;
                state     <= S_MOVE;
              end
              2'b10:   state <= S_WAIT_LINE;
              default: state <= S_HALT;
            endcase
          end
          S_WAIT_Y, S_WAIT_LINE, S_MOVE: begin
            if (step_done) begin
              m_write_n <= 2'b11;
              if (pc == LAST_PC) begin
                state <= S_HALT;
              end else begin
                pc    <= pc + 4'd1;
                state <= S_FETCH;
              end
            end
          end
          S_IDLE, S_HALT: state <= state;
          default:        state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tqvp_vga_copper.sv
// Bench for tqvp_vga_copper: register-map vector table plus directed
// multi-cycle sequences, with a scoreboard on the VGA master port.
module tb_tqvp_vga_copper;

  logic        clk;
  logic        rst_n;
  logic [5:0]  address;
  logic [31:0] data_in;
  logic [1:0]  data_write_n;
  logic [1:0]  data_read_n;
  logic [31:0] data_out;
  logic        data_ready;
  logic [9:0]  vga_y;
  logic        vga_new_scanline;
  logic        frame_start;
  logic        m_busy;
  logic [5:0]  m_address;
  logic [31:0] m_data;
  logic [1:0]  m_write_n;

  tqvp_vga_copper dut (
    .clk(clk), .rst_n(rst_n), .address(address), .data_in(data_in),
    .data_write_n(data_write_n), .data_read_n(data_read_n),
    .data_out(data_out), .data_ready(data_ready), .vga_y(vga_y),
    .vga_new_scanline(vga_new_scanline), .frame_start(frame_start),
    .m_busy(m_busy), .m_address(m_address), .m_data(m_data),
    .m_write_n(m_write_n)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int acc_count = 0;
  int last_acc_cyc = -1;
  logic [37:0] exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // scoreboard on accepted master writes
  always @(negedge clk) begin
    if (rst_n && m_write_n == 2'b10 && !m_busy) begin
      acc_count++;
      last_acc_cyc = cyc;
      if (exp_q.size() == 0) begin
        check("unexpected_write", {26'd0, m_address, m_data}, 64'd0);
      end else begin
        logic [37:0] e;
        e = exp_q.pop_front();
        check("write_content", {26'd0, m_address, m_data}, {26'd0, e});
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [5:0] a, input logic [31:0] d, input logic [1:0] wn);
    address = a;
    data_in = d;
    data_write_n = wn;
    tick();
    data_write_n = 2'b11;
  endtask

  task automatic rd_check(input string name, input logic [5:0] a, input logic [31:0] exp);
    address = a;
    data_read_n = 2'b10;
    #1;
    check(name, {32'd0, data_out}, {32'd0, exp});
    data_read_n = 2'b11;
  endtask

  task automatic pulse_frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  typedef struct {
    logic [5:0]  addr;
    logic [1:0]  wn;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs [9];

  initial begin
    int t0, a0, s;
    rst_n = 1'b0; address = 6'd0; data_in = 32'd0; data_write_n = 2'b11;
    data_read_n = 2'b11; vga_y = 10'd0; vga_new_scanline = 1'b0;
    frame_start = 1'b0; m_busy = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // reset state
    rd_check("reset_status", 6'h34, 32'd0);
    check("reset_m_write_n", {62'd0, m_write_n}, 64'd3);
    check("reset_m_address", {58'd0, m_address}, 64'd0);
    check("reset_m_data", {32'd0, m_data}, 64'd0);
    check("data_ready", {63'd0, data_ready}, 64'd1);
    repeat (3) begin
      pulse_frame();
      repeat (4) tick();
    end
    check("disabled_no_writes", acc_count, 0);

    // register map table
    vecs[0] = '{6'h00, 2'b10, 32'h4030_0015, 32'h4030_0015};
    vecs[1] = '{6'h00, 2'b01, 32'hDEAD_BEEF, 32'h4030_0015};
    vecs[2] = '{6'h00, 2'b00, 32'h1234_5678, 32'h4030_0015};
    vecs[3] = '{6'h04, 2'b10, 32'hC000_0000, 32'hC000_0000};
    vecs[4] = '{6'h2C, 2'b10, 32'hC000_0000, 32'hC000_0000};
    vecs[5] = '{6'h38, 2'b10, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[6] = '{6'h3C, 2'b11, 32'h0000_0000, 32'h0000_0000};
    vecs[7] = '{6'h30, 2'b11, 32'h0000_0000, 32'h0000_0000};
    vecs[8] = '{6'h34, 2'b11, 32'h0000_0000, 32'h0000_0000};
    for (int i = 0; i < 9; i++) begin
      if (vecs[i].wn != 2'b11) wr(vecs[i].addr, vecs[i].wdata, vecs[i].wn);
      rd_check($sformatf("regmap_vec%0d", i), vecs[i].addr, vecs[i].exp_rd);
    end

    // single MOVE then END
    wr(6'h30, 32'd1, 2'b10);
    rd_check("ctrl_readback", 6'h30, 32'd1);
    exp_q.push_back({6'h30, 32'h15});
    a0 = acc_count;
    pulse_frame();
    rd_check("status_fetch_T1", 6'h34, 32'h1);
    tick();
    check("move_offer_T2", {62'd0, m_write_n}, 64'd2);
    check("move_addr_T2", {58'd0, m_address}, 64'h30);
    check("move_data_T2", {32'd0, m_data}, 64'h15);
    repeat (4) tick();
    rd_check("status_halt_pc1", 6'h34, 32'hD);
    check("single_move_count", acc_count - a0, 1);

    // WAIT_Y 100 then MOVE
    wr(6'h30, 32'd0, 2'b10);
    wr(6'h00, 32'h0000_0064, 2'b10);
    wr(6'h04, 32'h4031_003F, 2'b10);
    wr(6'h08, 32'hC000_0000, 2'b10);
    wr(6'h30, 32'd1, 2'b10);
    exp_q.push_back({6'h31, 32'h3F});
    a0 = acc_count;
    t0 = 0;
    vga_y = 10'd0;
    pulse_frame();
    for (int y = 0; y <= 120; y++) begin
      vga_y = 10'(y);
      if (y == 100) t0 = cyc;
      tick();
    end
    check("wait_y_latency", last_acc_cyc, t0 + 2);
    check("wait_y_once", acc_count - a0, 1);

    // WAIT_LINE / MOVE with busy stalls
    wr(6'h30, 32'd0, 2'b10);
    wr(6'h00, 32'h8000_0000, 2'b10);
    wr(6'h04, 32'h4030_0001, 2'b10);
    wr(6'h08, 32'h8000_0000, 2'b10);
    wr(6'h0C, 32'h4030_0002, 2'b10);
    wr(6'h10, 32'hC000_0000, 2'b10);
    wr(6'h30, 32'd1, 2'b10);
    exp_q.push_back({6'h30, 32'h1});
    exp_q.push_back({6'h30, 32'h2});
    a0 = acc_count;
    pulse_frame();
    tick();
    m_busy = 1'b1;
    vga_new_scanline = 1'b1;
    tick();
    vga_new_scanline = 1'b0;
    tick();
    for (int k = 0; k < 3; k++) begin
      check($sformatf("busy_hold_wn%0d", k), {62'd0, m_write_n}, 64'd2);
      check($sformatf("busy_hold_data%0d", k), {26'd0, m_address, m_data}, {26'd0, 6'h30, 32'h1});
      tick();
    end
    check("busy_none_accepted", acc_count - a0, 0);
    m_busy = 1'b0;
    t0 = cyc;
    tick();
    check("busy_accept_4th", last_acc_cyc, t0);
    check("after_accept_wn", {62'd0, m_write_n}, 64'd3);
    repeat (5) tick();
    check("second_waits_line", acc_count - a0, 1);
    vga_new_scanline = 1'b1;
    s = cyc;
    tick();
    vga_new_scanline = 1'b0;
    repeat (3) tick();
    check("second_after_line", last_acc_cyc, s + 2);
    check("wait_line_count", acc_count - a0, 2);

    // frame_start during a stalled MOVE, then disable drops it
    wr(6'h30, 32'd0, 2'b10);
    wr(6'h00, 32'h4030_0015, 2'b10);
    wr(6'h04, 32'hC000_0000, 2'b10);
    wr(6'h30, 32'd1, 2'b10);
    a0 = acc_count;
    m_busy = 1'b1;
    pulse_frame();
    tick();
    check("stalled_offer", {62'd0, m_write_n}, 64'd2);
    pulse_frame();
    rd_check("restart_fetch_pc0", 6'h34, 32'h1);
    check("restart_wn_idle", {62'd0, m_write_n}, 64'd3);
    tick();
    wr(6'h30, 32'd0, 2'b10);
    rd_check("disable_idle", 6'h34, 32'h0);
    check("disable_wn", {62'd0, m_write_n}, 64'd3);
    m_busy = 1'b0;
    tick();
    check("abandoned_no_write", acc_count - a0, 0);

    // WAIT_Y beyond visible lines, then disable mid-WAIT_Y
    wr(6'h00, 32'h0000_0320, 2'b10);
    wr(6'h30, 32'd1, 2'b10);
    vga_y = 10'd767;
    pulse_frame();
    repeat (4) tick();
    rd_check("wait_y_800_holds", 6'h34, 32'h2);
    vga_y = 10'd800;
    tick();
    rd_check("wait_y_800_met", 6'h34, 32'h9);
    tick();
    rd_check("halt_after_end", 6'h34, 32'hD);
    vga_y = 10'd0;
    pulse_frame();
    repeat (3) tick();
    rd_check("in_wait_y", 6'h34, 32'h2);
    wr(6'h30, 32'd0, 2'b10);
    rd_check("clear_mid_wait", 6'h34, 32'h0);
    check("clear_mid_wait_wn", {62'd0, m_write_n}, 64'd3);

    // 12 back-to-back MOVEs
    for (int i = 0; i < 12; i++) begin
      logic [31:0] w;
      w = 32'h4000_0000 | (32'(i) << 16) | (32'h100 + 32'(i));
      wr(6'(i * 4), w, 2'b10);
      exp_q.push_back({6'(i), 32'h100 + 32'(i)});
    end
    wr(6'h30, 32'd1, 2'b10);
    a0 = acc_count;
    t0 = cyc;
    pulse_frame();
    repeat (26) tick();
    check("twelve_moves_count", acc_count - a0, 12);
    check("twelve_moves_last", last_acc_cyc, t0 + 24);
    rd_check("twelve_moves_halt", 6'h34, 32'h5D);
    wr(6'h00, 32'hFFFF_FFFF, 2'b01);
    rd_check("entry0_16bit_ignored", 6'h00, 32'h4000_0100);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
